// File: rtl/gray_code_conv.sv
// Streaming Gray<->binary converter with a single registered output stage and a saturating transfer counter.
// Optional Gray-adjacency checker enabled by defining GRAY_ADJ_CHECK_EN; adj_err is tied 0 otherwise.
//   state | meaning
//   EMPTY | output register holds nothing, out_valid=0
//   FULL  | output register holds a result, out_valid=1
module gray_code_conv #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_mode,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] conv_count,
  input  logic             clr_count,
  output logic             adj_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_xfer, out_xfer;
  logic [WIDTH-1:0] conv_res;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [WIDTH-1:0] bin2gray(input logic [WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign out_valid  = (state_q == FULL);
  assign in_ready   = !out_valid || out_ready;
  assign in_xfer    = in_valid && in_ready;
  assign out_xfer   = out_valid && out_ready;
  assign conv_res   = in_mode ? bin2gray(in_data) : gray2bin(in_data);
  assign out_data   = data_q;
  assign out_mode   = mode_q;
  assign conv_count = count_q;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    mode_d  = mode_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = FULL;
          data_d  = conv_res;
          mode_d  = in_mode;
        end
      end
      FULL: begin
        if (in_xfer) begin
          data_d = conv_res;
          mode_d = in_mode;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Clear wins over a same-cycle transfer.
  always_comb begin
    count_d = count_q;
    if (clr_count)
      count_d = '0;
    else if (in_xfer && (count_q != CNT_MAX))
      count_d = count_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      data_q  <= '0;
      mode_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      count_q <= count_d;
    end
  end

`ifdef GRAY_ADJ_CHECK_EN
  logic [WIDTH-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;
  logic             adj_err_q, adj_err_d;
  logic [WIDTH-1:0] gray_word;

  // The Gray side of a transfer is the input in mode 0 and the result in mode 1.
  assign gray_word = in_mode ? conv_res : in_data;

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    adj_err_d   = adj_err_q;
    if (clr_count) begin
      prev_d      = '0;
      have_prev_d = 1'b0;
      adj_err_d   = 1'b0;
    end else if (in_xfer) begin
      if (have_prev_q && ($countones(prev_q ^ gray_word) != 1))
        adj_err_d = 1'b1;
      prev_d      = gray_word;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      adj_err_q   <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      adj_err_q   <= adj_err_d;
    end
  end

  assign adj_err = adj_err_q;
`else
  assign adj_err = 1'b0;
`endif

endmodule

// File: tb/tb_gray_code_conv.sv
// Self-checking bench for gray_code_conv (WIDTH=8, CNT_W=3) against an arithmetic reference model.
module tb_gray_code_conv;
  localparam int W  = 8;
  localparam int CW = 3;
  localparam int CMAX = 7;
`ifdef GRAY_ADJ_CHECK_EN
  localparam bit ADJ_EN = 1'b1;
`else
  localparam bit ADJ_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid, in_ready, in_mode;
  logic [W-1:0]  in_data;
  logic          out_valid, out_ready, out_mode;
  logic [W-1:0]  out_data;
  logic [CW-1:0] conv_count;
  logic          clr_count, adj_err;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Reference model state
  logic         m_valid, m_mode, m_adj, m_have;
  logic [W-1:0] m_data, m_prev;
  int           m_cnt;

  gray_code_conv #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode), .out_data(out_data),
    .conv_count(conv_count), .clr_count(clr_count), .adj_err(adj_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_g2b(input logic [W-1:0] g);
    logic [W-1:0] b = '0;
    for (int s = 0; s < W; s++) b = b ^ (g >> s);
    return b;
  endfunction

  function automatic logic [W-1:0] ref_b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic int ref_pop(input logic [W-1:0] x);
    int n = 0;
    for (int i = 0; i < W; i++) n += int'(x[i]);
    return n;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_mode = 1'b0; m_data = '0; m_cnt = 0;
    m_adj = 1'b0; m_have = 1'b0; m_prev = '0;
  endtask

  // Advance one clock; inputs must be stable from before the edge.
  task automatic tick();
    logic ir, ix, ox;
    logic [W-1:0] res, gw;
    ir  = !m_valid || out_ready;
    ix  = in_valid && ir;
    ox  = m_valid && out_ready;
    res = in_mode ? ref_b2g(in_data) : ref_g2b(in_data);
    gw  = in_mode ? res : in_data;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (ix) begin
        m_valid = 1'b1; m_data = res; m_mode = in_mode;
      end else if (ox) begin
        m_valid = 1'b0;
      end
      if (clr_count) m_cnt = 0;
      else if (ix && m_cnt < CMAX) m_cnt++;
      if (ADJ_EN) begin
        if (clr_count) begin
          m_adj = 1'b0; m_have = 1'b0; m_prev = '0;
        end else if (ix) begin
          if (m_have && ref_pop(m_prev ^ gw) != 1) m_adj = 1'b1;
          m_prev = gw; m_have = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    chk_cnt++; if (out_data !== '0) begin err_cnt++; $display("FAIL reset_out_data got=%h exp=00", out_data); end
    chk_cnt++; if (out_mode !== 1'b0) begin err_cnt++; $display("FAIL reset_out_mode got=%b exp=0", out_mode); end
    chk_cnt++; if (conv_count !== '0) begin err_cnt++; $display("FAIL reset_count got=%0d exp=0", conv_count); end
    chk_cnt++; if (adj_err !== 1'b0) begin err_cnt++; $display("FAIL reset_adj_err got=%b exp=0", adj_err); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_gray3();
    logic [2:0] codes [8];
    codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_mode = 1'b0; in_data = {5'b0, codes[i]};
      #1;
      chk_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL gray3_in_ready[%0d] got=%b exp=1", i, in_ready); end
      tick();
      chk_cnt++;
      if (out_valid !== 1'b1 || out_data !== W'(i) || out_mode !== 1'b0) begin
        err_cnt++; $display("FAIL gray3_out[%0d] got v=%b d=%h m=%b exp v=1 d=%h m=0", i, out_valid, out_data, out_mode, W'(i));
      end
    end
    chk_cnt++; if (adj_err !== 1'b0) begin err_cnt++; $display("FAIL gray3_adj got=%b exp=0", adj_err); end
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL gray3_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'hA5;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready0 got=%b exp=1", in_ready); end
    tick();
    chk_cnt++; if (out_data !== 8'hF7 || out_mode !== 1'b1 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_bin2gray got d=%h m=%b v=%b exp d=f7 m=1 v=1", out_data, out_mode, out_valid); end
    in_mode = 1'b0; in_data = 8'hF7;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL b2b_ready1 got=%b exp=1", in_ready); end
    tick();
    chk_cnt++; if (out_data !== 8'hA5 || out_mode !== 1'b0 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL b2b_gray2bin got d=%h m=%b v=%b exp d=a5 m=0 v=1", out_data, out_mode, out_valid); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h3C;
    tick();
    chk_cnt++; if (out_data !== 8'h22 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_load got d=%h v=%b exp d=22 v=1", out_data, out_valid); end
    in_mode = 1'b0; in_data = 8'h99;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
      tick();
      chk_cnt++; if (out_data !== 8'h22 || out_mode !== 1'b1 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_hold[%0d] got d=%h m=%b v=%b exp d=22 m=1 v=1", i, out_data, out_mode, out_valid); end
    end
    out_ready = 1'b1;
    #1;
    chk_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    tick();
    chk_cnt++; if (out_data !== 8'hEE || out_mode !== 1'b0 || out_valid !== 1'b1) begin err_cnt++; $display("FAIL bp_simul got d=%h m=%b v=%b exp d=ee m=0 v=1", out_data, out_mode, out_valid); end
    chk_cnt++; if (conv_count !== CW'(m_cnt)) begin err_cnt++; $display("FAIL bp_count got=%0d exp=%0d", conv_count, m_cnt); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_count_sat();
    in_valid = 1'b0; clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk_cnt++; if (conv_count !== '0) begin err_cnt++; $display("FAIL cnt_clr got=%0d exp=0", conv_count); end
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      in_data = W'(i);
      tick();
      chk_cnt++; if (conv_count !== CW'((i > 7) ? 7 : i)) begin err_cnt++; $display("FAIL cnt_sat[%0d] got=%0d exp=%0d", i, conv_count, (i > 7) ? 7 : i); end
    end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk_cnt++; if (conv_count !== '0) begin err_cnt++; $display("FAIL cnt_clr_with_xfer got=%0d exp=0", conv_count); end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_adj_check();
    logic [W-1:0] seq [4];
    logic         exp [4];
    seq = '{8'h00, 8'h01, 8'h03, 8'h06};
    exp = '{1'b0, 1'b0, 1'b0, ADJ_EN};
    in_valid = 1'b0; clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk_cnt++; if (adj_err !== 1'b0) begin err_cnt++; $display("FAIL adj_clr0 got=%b exp=0", adj_err); end
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_data = seq[i];
      tick();
      chk_cnt++; if (adj_err !== exp[i]) begin err_cnt++; $display("FAIL adj_seq[%0d] got=%b exp=%b", i, adj_err, exp[i]); end
    end
    in_valid = 1'b0;
    tick();
    chk_cnt++; if (adj_err !== ADJ_EN) begin err_cnt++; $display("FAIL adj_sticky got=%b exp=%b", adj_err, ADJ_EN); end
    clr_count = 1'b1;
    tick();
    clr_count = 1'b0;
    chk_cnt++; if (adj_err !== 1'b0) begin err_cnt++; $display("FAIL adj_clr1 got=%b exp=0", adj_err); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h55;
    tick();
    in_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_cnt++; if (out_valid !== 1'b0 || out_data !== '0 || conv_count !== '0 || adj_err !== 1'b0) begin
      err_cnt++; $display("FAIL mid_reset got v=%b d=%h c=%0d a=%b exp all 0", out_valid, out_data, conv_count, adj_err);
    end
    tick();
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_mode = 1'b0; in_data = 8'hF7;
    tick();
    chk_cnt++; if (out_data !== 8'hA5 || out_valid !== 1'b1 || conv_count !== 3'd1) begin
      err_cnt++; $display("FAIL post_reset got d=%h v=%b c=%0d exp d=a5 v=1 c=1", out_data, out_valid, conv_count);
    end
    in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 3) != 0);
      in_mode   = 1'($urandom_range(0, 1));
      in_data   = W'($urandom);
      clr_count = ($urandom_range(0, 15) == 0);
      #1;
      chk_cnt++; if (in_ready !== (!m_valid || out_ready)) begin err_cnt++; $display("FAIL rnd_in_ready[%0d] got=%b exp=%b", n, in_ready, !m_valid || out_ready); end
      tick();
      chk_cnt++;
      if (out_valid !== m_valid || out_data !== m_data || out_mode !== m_mode) begin
        err_cnt++; $display("FAIL rnd_out[%0d] got v=%b d=%h m=%b exp v=%b d=%h m=%b", n, out_valid, out_data, out_mode, m_valid, m_data, m_mode);
      end
      chk_cnt++; if (conv_count !== CW'(m_cnt)) begin err_cnt++; $display("FAIL rnd_count[%0d] got=%0d exp=%0d", n, conv_count, m_cnt); end
      chk_cnt++; if (adj_err !== m_adj) begin err_cnt++; $display("FAIL rnd_adj[%0d] got=%b exp=%b", n, adj_err, m_adj); end
    end
    in_valid = 1'b0; clr_count = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b0; clr_count = 1'b0;
    model_reset();
    test_reset();
    test_gray3();
    test_back_to_back();
    test_backpressure();
    test_count_sat();
    test_adj_check();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end
endmodule
